// File: rtl/rr_delay_arbiter.sv
// Round-robin arbiter feeding a stallable fixed-latency delay chain; each beat carries its requester ID.
// Optional per-requester accept counters are enabled with `define RR_DELAY_ARB_PERF_CNT_EN.
module rr_delay_arbiter #(
  parameter int width_p   = 8,
  parameter int num_req_p = 4,
  parameter int delay_p   = 4,
  localparam int id_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p*width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]         req_valid_i,
  output logic [num_req_p-1:0]         req_ready_o,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  output logic [id_w_lp-1:0]           id_o,
  input  logic                         ready_i
`ifdef RR_DELAY_ARB_PERF_CNT_EN
  ,output logic [num_req_p*16-1:0]     accept_cnt_o
`endif
);

  logic [delay_p-1:0] r_valid;
  logic [width_p-1:0] r_data [delay_p];
  logic [id_w_lp-1:0] r_id   [delay_p];
  logic [id_w_lp-1:0] r_last_grant;

  logic               w_advance;
  logic               w_found;
  logic               w_accept;
  logic [id_w_lp-1:0] w_winner;
  logic [width_p-1:0] w_sel_data;

  assign w_advance = ~r_valid[delay_p-1] | ready_i;
  assign w_accept  = w_found & w_advance & ~reset_i;

  // Rotating-priority search: requesters above last_grant first, then wrap to the rest.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_sel_data = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!w_found && req_valid_i[k] && (id_w_lp'(k) > r_last_grant)) begin
        w_found    = 1'b1;
        w_winner   = id_w_lp'(k);
        w_sel_data = req_data_i[k*width_p +: width_p];
      end else begin
        w_found    = w_found;
      end
    end
    for (int k = 0; k < num_req_p; k++) begin
      if (!w_found && req_valid_i[k] && (id_w_lp'(k) <= r_last_grant)) begin
        w_found    = 1'b1;
        w_winner   = id_w_lp'(k);
        w_sel_data = req_data_i[k*width_p +: width_p];
      end else begin
        w_found    = w_found;
      end
    end
  end

  // One-hot ready to the winner, only when the chain can take a beat.
  always_comb begin
    req_ready_o = '0;
    for (int k = 0; k < num_req_p; k++) begin
      req_ready_o[k] = w_accept & (w_winner == id_w_lp'(k));
    end
  end

  // Delay chain: shifts as a whole on advance, holds as a whole on stall.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= '0;
      for (int s = 0; s < delay_p; s++) begin
        r_data[s] <= '0;
        r_id[s]   <= '0;
      end
    end else if (w_advance) begin
      for (int s = delay_p-1; s > 0; s--) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
        r_id[s]    <= r_id[s-1];
      end
      r_valid[0] <= w_accept;
      r_data[0]  <= w_accept ? w_sel_data : '0;
      r_id[0]    <= w_accept ? w_winner : '0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Grant pointer moves only on an actual accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_last_grant <= id_w_lp'(num_req_p-1);
    end else if (w_accept) begin
      r_last_grant <= w_winner;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign valid_o = r_valid[delay_p-1];
  assign data_o  = r_data[delay_p-1];
  assign id_o    = r_id[delay_p-1];

`ifdef RR_DELAY_ARB_PERF_CNT_EN
  for (genvar k = 0; k < num_req_p; k++) begin : g_cnt
    logic [15:0] r_cnt;

    // Saturating accept counter for requester k.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_cnt <= 16'h0000;
      end else if (w_accept && (w_winner == id_w_lp'(k)) && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'h0001;
      end else begin
        r_cnt <= r_cnt;
      end
    end

    assign accept_cnt_o[k*16 +: 16] = r_cnt;
  end
`endif

endmodule
